// File: rtl/spi_vector_regs_if.sv
// Write-only SPI link (mode 0, MSB first) to the view-vector register bank.
// The host drives the master modport; spi_vector_regs takes the slave modport.
interface spi_vector_regs_if;
    logic i_sclk;
    logic i_mosi;
    logic i_ss_n;
    logic o_miso;

    modport master (
        output i_sclk,
        output i_mosi,
        output i_ss_n,
        input  o_miso
    );

    modport slave (
        input  i_sclk,
        input  i_mosi,
        input  i_ss_n,
        output o_miso
    );
endinterface

// File: rtl/spi_vector_regs.sv
// Frame-synchronised view-vector bank loaded over SPI; vectors are Qm.Qn (QM+QN bits).
// Optional macro SPI_VEC_READBACK_EN: o_miso streams the live set during each write.
//
// state | meaning
// IDLE  | waiting for a fresh i_ss_n falling edge
// SHIFT | shifting i_mosi on each synchronised i_sclk rise
// DONE  | one cycle: accept (exact bit count) or flag rx error
module spi_vector_regs #(
    parameter int NVEC = 6,
    parameter int QM   = 8,
    parameter int QN   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    spi_vector_regs_if.slave        spi,
    input  logic                    i_frame_end,
    output logic signed [QM+QN-1:0] playerX,
    output logic signed [QM+QN-1:0] playerY,
    output logic signed [QM+QN-1:0] facingX,
    output logic signed [QM+QN-1:0] facingY,
    output logic signed [QM+QN-1:0] vplaneX,
    output logic signed [QM+QN-1:0] vplaneY,
    output logic                    o_load_pending,
    output logic                    o_rx_err
);
    localparam int W     = QM + QN;
    localparam int NBITS = NVEC * W;
    localparam int CW    = $clog2(NBITS + 2);

    localparam logic [W-1:0] V_ZERO  = '0;
    localparam logic [W-1:0] V_ONE   = W'(1) << QN;
    localparam logic [W-1:0] V_P15   = W'(3) << (QN - 1);
    localparam logic [W-1:0] V_NHALF = ~(W'(1) << (QN - 1)) + W'(1);

    localparam logic [NBITS-1:0] RESET_VEC = {V_P15, V_P15, V_ZERO, V_ONE, V_NHALF, V_ZERO};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } rx_state_t;

    logic [1:0]       sclk_sync;
    logic [1:0]       mosi_sync;
    logic [1:0]       ss_sync;
    logic             sclk_d;
    logic             ss_d;
    logic             sclk_rise;
    logic             ss_fall;
    logic             ss_rise;

    rx_state_t        state;
    logic [CW-1:0]    bit_cnt;
    logic [NBITS-1:0] shift_reg;
    logic [NBITS-1:0] pending_vec;
    logic [NBITS-1:0] live_vec;

    // Select resets to "asserted" so a bus held low across reset never
    // produces a falling edge; only a fresh high-to-low starts a transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            ss_sync   <= 2'b00;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi.i_sclk};
            mosi_sync <= {mosi_sync[0], spi.i_mosi};
            ss_sync   <= {ss_sync[0], spi.i_ss_n};
            sclk_d    <= sclk_sync[1];
            ss_d      <= ss_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign ss_fall   = ~ss_sync[1] & ss_d;
    assign ss_rise   = ss_sync[1] & ~ss_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            pending_vec    <= '0;
            live_vec       <= RESET_VEC;
            o_load_pending <= 1'b0;
            o_rx_err       <= 1'b0;
        end else begin
            // Commit first; a same-cycle DONE below overrides the pending flag
            // so the fresh set waits for the next frame end.
            if (i_frame_end && o_load_pending) begin
                live_vec       <= pending_vec;
                o_load_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shift_reg <= {shift_reg[NBITS-2:0], mosi_sync[1]};
                        if (bit_cnt != CW'(NBITS + 1)) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    if (ss_rise) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bit_cnt == CW'(NBITS)) begin
                        pending_vec    <= shift_reg;
                        o_load_pending <= 1'b1;
                        o_rx_err       <= 1'b0;
                    end else begin
                        o_rx_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign playerX = live_vec[5*W +: W];
    assign playerY = live_vec[4*W +: W];
    assign facingX = live_vec[3*W +: W];
    assign facingY = live_vec[2*W +: W];
    assign vplaneX = live_vec[1*W +: W];
    assign vplaneY = live_vec[0 +: W];

`ifdef SPI_VEC_READBACK_EN
    logic             sclk_fall;
    logic [NBITS-1:0] tx_reg;

    assign sclk_fall = ~sclk_sync[1] & sclk_d;

    // Snapshot of the displayed set, shifted out while the next set comes in.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_reg <= '0;
        end else if (state == IDLE && ss_fall) begin
            tx_reg <= live_vec;
        end else if (state == SHIFT && sclk_fall) begin
            tx_reg <= {tx_reg[NBITS-2:0], 1'b0};
        end
    end

    assign spi.o_miso = tx_reg[NBITS-1];
`else
    assign spi.o_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_vector_regs.sv
// Self-checking bench for spi_vector_regs: model + expected-live queue, one task per scenario.
// Honours SPI_VEC_READBACK_EN for the o_miso expectations.
module tb_spi_vector_regs;
    localparam int W     = 16;
    localparam int NBITS = 96;
    localparam logic [NBITS-1:0] RESET_VEC =
        {16'h0180, 16'h0180, 16'h0000, 16'h0100, 16'hFF80, 16'h0000};

    logic clk = 1'b0;
    logic reset;
    logic i_frame_end;
    logic signed [W-1:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
    logic o_load_pending;
    logic o_rx_err;
    logic [NBITS-1:0] live_obs;

    spi_vector_regs_if spi();

    spi_vector_regs dut (
        .clk            (clk),
        .reset          (reset),
        .spi            (spi),
        .i_frame_end    (i_frame_end),
        .playerX        (playerX),
        .playerY        (playerY),
        .facingX        (facingX),
        .facingY        (facingY),
        .vplaneX        (vplaneX),
        .vplaneY        (vplaneY),
        .o_load_pending (o_load_pending),
        .o_rx_err       (o_rx_err)
    );

    always #5 clk = ~clk;

    assign live_obs = {playerX, playerY, facingX, facingY, vplaneX, vplaneY};

    int n_checks = 0;
    int n_fail   = 0;

    logic [NBITS-1:0] m_live;
    logic [NBITS-1:0] m_pending;
    bit               m_pend_valid;
    bit               m_err;
    logic [NBITS-1:0] exp_q[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_live       = RESET_VEC;
        m_pending    = '0;
        m_pend_valid = 1'b0;
        m_err        = 1'b0;
    endtask

    task automatic model_fe();
        if (m_pend_valid) begin
            m_live       = m_pending;
            m_pend_valid = 1'b0;
        end
        exp_q.push_back(m_live);
    endtask

    task automatic model_write(input logic [127:0] data, input int nbits);
        if (nbits == NBITS) begin
            m_pending    = data[NBITS-1:0];
            m_pend_valid = 1'b1;
            m_err        = 1'b0;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic pulse_frame_end();
        model_fe();
        i_frame_end = 1'b1;
        tick(1);
        i_frame_end = 1'b0;
    endtask

    // Full transaction: bits data[nbits-1:0] MSB first; optionally fires
    // i_frame_end exactly in the DUT's DONE cycle. Ends 5 clk after ss rise.
    task automatic spi_xfer(input logic [127:0] data, input int nbits, input bit fe_at_done);
        logic [127:0] rx;
        logic [127:0] exp_rx;
        rx = '0;
`ifdef SPI_VEC_READBACK_EN
        exp_rx = {m_live, 32'b0} >> (128 - nbits);
`else
        exp_rx = '0;
`endif
        spi.i_ss_n = 1'b0;
        tick(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi.i_mosi = data[i];
            tick(4);
            rx = {rx[126:0], spi.o_miso};
            spi.i_sclk = 1'b1;
            tick(4);
            spi.i_sclk = 1'b0;
        end
        tick(4);
        spi.i_ss_n = 1'b1;
        if (fe_at_done) begin
            tick(3);
            pulse_frame_end();
            tick(1);
        end else begin
            tick(5);
        end
        model_write(data, nbits);
        n_checks++;
        if (rx !== exp_rx) begin
            n_fail++;
            $display("FAIL miso_stream nbits=%0d got=%h exp=%h", nbits, rx, exp_rx);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        tick(1);
        n_checks++;
        if (live_obs !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_live got=%h exp=%h", live_obs, RESET_VEC);
        end
        n_checks++;
        if (o_load_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pending got=%b exp=0", o_load_pending);
        end
        n_checks++;
        if (o_rx_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err got=%b exp=0", o_rx_err);
        end
        n_checks++;
        if (spi.o_miso !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_miso got=%b exp=0", spi.o_miso);
        end
    endtask

    task automatic test_valid_write();
        logic [NBITS-1:0] exp;
        // playerX = 2.25, facingY = -1.0, others 0
        spi_xfer({32'b0, 16'h0240, 16'h0000, 16'h0000, 16'hFF00, 16'h0000, 16'h0000}, NBITS, 1'b0);
        n_checks++;
        if (live_obs !== m_live) begin
            n_fail++;
            $display("FAIL write_live_hold got=%h exp=%h", live_obs, m_live);
        end
        n_checks++;
        if (o_load_pending !== m_pend_valid) begin
            n_fail++;
            $display("FAIL write_pending got=%b exp=%b", o_load_pending, m_pend_valid);
        end
        pulse_frame_end();
        exp = exp_q.pop_front();
        n_checks++;
        if (live_obs !== exp) begin
            n_fail++;
            $display("FAIL commit_live got=%h exp=%h", live_obs, exp);
        end
        n_checks++;
        if (o_load_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_pending_clear got=%b exp=0", o_load_pending);
        end
        tick(2);
    endtask

    task automatic test_bad_count();
        logic [NBITS-1:0] a;
        logic [NBITS-1:0] exp;
        a = {$urandom, $urandom, $urandom};
        spi_xfer({32'b0, a} >> 1, NBITS - 1, 1'b0);
        n_checks++;
        if (o_rx_err !== 1'b1 || o_load_pending !== m_pend_valid) begin
            n_fail++;
            $display("FAIL short_write err=%b pend=%b exp err=1 pend=%b", o_rx_err, o_load_pending, m_pend_valid);
        end
        spi_xfer({32'b0, a}, NBITS, 1'b0);
        n_checks++;
        if (o_rx_err !== 1'b0 || o_load_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear err=%b pend=%b exp err=0 pend=1", o_rx_err, o_load_pending);
        end
        spi_xfer({31'b0, ~a, 1'b1}, NBITS + 1, 1'b0);
        n_checks++;
        if (o_rx_err !== 1'b1 || o_load_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL long_write err=%b pend=%b exp err=1 pend=1", o_rx_err, o_load_pending);
        end
        pulse_frame_end();
        exp = exp_q.pop_front();
        n_checks++;
        if (live_obs !== exp) begin
            n_fail++;
            $display("FAIL pending_untouched got=%h exp=%h", live_obs, exp);
        end
        tick(2);
    endtask

    task automatic test_last_write_wins();
        logic [NBITS-1:0] exp;
        spi_xfer({32'b0, $urandom, $urandom, $urandom}, NBITS, 1'b0);
        spi_xfer({32'b0, $urandom, $urandom, $urandom}, NBITS, 1'b0);
        pulse_frame_end();
        exp = exp_q.pop_front();
        n_checks++;
        if (live_obs !== exp) begin
            n_fail++;
            $display("FAIL last_write_wins got=%h exp=%h", live_obs, exp);
        end
        tick(2);
    endtask

    task automatic test_collision();
        logic [NBITS-1:0] exp;
        spi_xfer({32'b0, $urandom, $urandom, $urandom}, NBITS, 1'b0);
        spi_xfer({32'b0, $urandom, $urandom, $urandom}, NBITS, 1'b1);
        exp = exp_q.pop_front();
        n_checks++;
        if (live_obs !== exp || o_load_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_old got=%h pend=%b exp=%h pend=1", live_obs, o_load_pending, exp);
        end
        pulse_frame_end();
        exp = exp_q.pop_front();
        n_checks++;
        if (live_obs !== exp || o_load_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_new got=%h pend=%b exp=%h pend=0", live_obs, o_load_pending, exp);
        end
        tick(2);
        // Nothing pending: the frame end in the DONE cycle commits nothing.
        spi_xfer({32'b0, $urandom, $urandom, $urandom}, NBITS, 1'b1);
        exp = exp_q.pop_front();
        n_checks++;
        if (live_obs !== exp || o_load_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_empty got=%h pend=%b exp=%h pend=1", live_obs, o_load_pending, exp);
        end
        pulse_frame_end();
        exp = exp_q.pop_front();
        n_checks++;
        if (live_obs !== exp) begin
            n_fail++;
            $display("FAIL collision_empty_commit got=%h exp=%h", live_obs, exp);
        end
        tick(2);
    endtask

    task automatic test_reset_abort();
        logic [NBITS-1:0] exp;
        spi.i_ss_n = 1'b0;
        tick(4);
        for (int i = 0; i < 40; i++) begin
            spi.i_mosi = i[0];
            tick(4);
            spi.i_sclk = 1'b1;
            tick(4);
            spi.i_sclk = 1'b0;
        end
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 56; i++) begin
            spi.i_mosi = ~i[0];
            tick(4);
            spi.i_sclk = 1'b1;
            tick(4);
            spi.i_sclk = 1'b0;
        end
        tick(4);
        spi.i_ss_n = 1'b1;
        tick(6);
        n_checks++;
        if (o_load_pending !== 1'b0 || o_rx_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ignored pend=%b err=%b exp pend=0 err=0", o_load_pending, o_rx_err);
        end
        pulse_frame_end();
        exp = exp_q.pop_front();
        n_checks++;
        if (live_obs !== exp) begin
            n_fail++;
            $display("FAIL abort_fe_noop got=%h exp=%h", live_obs, exp);
        end
        tick(2);
        spi_xfer({32'b0, $urandom, $urandom, $urandom}, NBITS, 1'b0);
        n_checks++;
        if (o_load_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_recover pend=%b exp=1", o_load_pending);
        end
        pulse_frame_end();
        exp = exp_q.pop_front();
        n_checks++;
        if (live_obs !== exp) begin
            n_fail++;
            $display("FAIL abort_recover_commit got=%h exp=%h", live_obs, exp);
        end
        tick(2);
    endtask

    initial begin
        reset       = 1'b1;
        i_frame_end = 1'b0;
        spi.i_sclk  = 1'b0;
        spi.i_mosi  = 1'b0;
        spi.i_ss_n  = 1'b1;
        model_reset();
        test_reset();
        test_valid_write();
        test_bad_count();
        test_last_write_wins();
        test_collision();
        test_reset_abort();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_vector_regs.md
# spi_vector_regs

Host-loadable, frame-synchronised register bank for the six view vectors: playerX, playerY, facingX, facingY, vplaneX and vplaneY. An external host shifts in a new vector set over a write-only SPI link. The block holds the new set as pending and commits it to its live outputs only at the frame-end pulse. Those live outputs feed the ray tracer and the debug overlay stage directly, so both see one stable vector set for an entire frame.

## Interface
Parameters:
- `NVEC`, default 6: number of `F vectors per transaction. Fixed at 6 for this design; the bit count is `NVEC*Qmn`.

Ports:
- `clk` in 1: system (pixel) clock.
- `reset` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `i_sclk` in 1: SPI clock, asynchronous to `clk`, mode 0.
- `i_mosi` in 1: SPI data, MSB first.
- `i_ss_n` in 1: SPI select, active low.
- `i_frame_end` in 1: one-`clk` pulse from the VGA timing block after the last visible line.
- `o_miso` out 1: readback data. Present only with the readback macro; otherwise tied 0.
- `playerX`, `playerY`, `facingX`, `facingY`, `vplaneX`, `vplaneY` out `F: live vectors.
- `o_load_pending` out 1: a complete vector set is buffered and awaiting commit.
- `o_rx_err` out 1: sticky; the last transaction had a bad bit count.

## Operation
- `i_sclk`, `i_mosi` and `i_ss_n` each pass through a 2-flop synchroniser. Edges are detected on the synchronised copies.
- RX state machine, states IDLE, SHIFT and DONE:
  - IDLE → SHIFT on an `i_ss_n` falling edge. This clears the bit counter.
  - SHIFT: on each `i_sclk` rising edge, shift `i_mosi` into a `NVEC*Qmn` shift register and increment the counter. The counter saturates at `NVEC*Qmn+1`.
  - SHIFT → DONE on an `i_ss_n` rising edge.
  - DONE, count == `NVEC*Qmn`: copy the shift register to the pending buffer, set `o_load_pending`, clear `o_rx_err`.
  - DONE, any other count: discard the data, set `o_rx_err`, leave pending untouched.
  - DONE → IDLE after one cycle.
- Field order in the stream, MSB first: playerX, playerY, facingX, facingY, vplaneX, vplaneY.
- Commit: on `i_frame_end` with `o_load_pending`=1, copy pending to the live outputs and clear `o_load_pending`. On `i_frame_end` with `o_load_pending`=0, nothing changes.
- A new complete transaction while `o_load_pending`=1 overwrites pending. Last write wins.
- Same-cycle collision, DONE(valid) and `i_frame_end`:
  - The commit uses the old pending contents.
  - The new data lands in pending and `o_load_pending` stays 1.
  - If nothing was pending, the new data waits for the next frame end.
- Reset values, all two's complement Qm.Qn:
  - playerX = 1.5, playerY = 1.5.
  - facingX = 0.0, facingY = 1.0.
  - vplaneX = -0.5, vplaneY = 0.0.
  - `o_load_pending`=0, `o_rx_err`=0, `o_miso`=0, FSM in IDLE.
- Reset mid-transaction aborts it. If `i_ss_n` is still low when reset releases, the block ignores the bus until a fresh falling edge.

## Timing
- Synchroniser plus edge detect: each SPI event acts 3 `clk` edges after the pin transition.
- SCLK high and low times must each be ≥ 3 `clk` periods.
- `i_ss_n` must be high for ≥ 3 `clk` between transactions.
- `o_load_pending` rises 1 `clk` after the `i_ss_n` rise is detected (DONE cycle), i.e. ≤ 5 `clk` after the pin rises.
- Live outputs change on the `clk` edge that samples `i_frame_end`=1. They are otherwise constant, registered and glitch-free.

## Configuration
- `SPI_VEC_READBACK_EN` defined:
  - On an `i_ss_n` falling edge, a TX shift register loads the live vectors.
  - `o_miso` presents its MSB, then shifts on each synchronised `i_sclk` falling edge.
  - The host therefore reads the currently displayed set while writing the next one.
- Undefined: no TX register; `o_miso` is constant 0.

## Test plan
- Reset held 2 cycles → live outputs = 1.5, 1.5, 0.0, 1.0, -0.5, 0.0; pending = 0; err = 0.
- Valid 6·Qmn-bit write of playerX=2.25, facingY=-1.0, others 0, with no frame end → outputs unchanged and `o_load_pending`=1. Then `i_frame_end` pulse → outputs equal the written values the next cycle and pending = 0.
- Write with one bit short → `o_rx_err`=1, pending unchanged. A following valid write clears `o_rx_err`.
- Two valid writes, A then B, before a frame end → commit yields B.
- `i_frame_end` in the same cycle as DONE of B with A pending → live = A and pending stays 1. Next `i_frame_end` → live = B.
- `SPI_VEC_READBACK_EN`: after reset, any transaction → `o_miso` stream equals the reset vector set, MSB first. Without the macro, `o_miso` = 0 throughout.
